// File: rtl/rs232c_pkg.sv
// -----------------------------------------------------------------------------
// rs232c_pkg
//   Shared definitions for the RS232C transmit scheduler slice: byte width,
//   transmit-sequencer state encoding and default sizing parameters.
// -----------------------------------------------------------------------------
package rs232c_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned DEF_DEPTH    = 16;
  localparam int unsigned DEF_AW       = 4;
  localparam int unsigned DEF_ACK_WAIT = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  // Explicit values keep the encoding identical to the legacy localparams.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rs232c_fifo.sv
// -----------------------------------------------------------------------------
// rs232c_fifo
//   Synchronous circular-buffer FIFO with occupancy count. Storage is plain
//   registers; the read port is the entry addressed by the registered read
//   pointer, so the head byte is visible without a read strobe.
//   A push while full is accepted only when a pop happens in the same cycle;
//   the occupancy then stays at DEPTH.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (pointers and count to 0)
//   push_i   in   write wdata_i this cycle
//   wdata_i  in   write data
//   pop_i    in   consume the head entry this cycle
//   rdata_o  out  head entry (mem[rd_ptr])
//   count_o  out  occupancy, 0..DEPTH
//   empty_o  out  count_o == 0
//   full_o   out  count_o == DEPTH
// -----------------------------------------------------------------------------
module rs232c_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Defensive gating: never pop an empty buffer, never overwrite a full one
  // unless the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end

  // Pointers wrap naturally because DEPTH == 2**AW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid. When full with a
  // simultaneous pop, wr_ptr == rd_ptr: the old head is read out combinationally
  // before this edge overwrites the slot.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rs232c_tx_sched.sv
// -----------------------------------------------------------------------------
// rs232c_tx_sched
//   Shares one RS232C serial transmitter between the CPU OUTPUTB path (cannot
//   be stalled) and a debug/loader source (valid/ready). Both feed a transmit
//   FIFO; a small sequencer pops one byte at a time, issues a single-cycle
//   start pulse and tracks the transmitter busy line, recovering if busy never
//   rises within ACK_WAIT cycles of the start.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   cpu_push      in   one-cycle byte push from the dispatcher
//   cpu_data      in   byte accompanying cpu_push
//   dbg_valid     in   debug source offers dbg_data
//   dbg_data      in   debug byte, held while dbg_valid && !dbg_ready
//   dbg_ready     out  debug byte accepted this cycle (combinational)
//   tx_busy       in   transmitter is shifting
//   tx_start      out  one-cycle start pulse to the transmitter
//   tx_data       out  byte for the transmitter, stable until the next pop
//   fifo_count    out  FIFO occupancy
//   fifo_empty    out  occupancy is zero
//   fifo_full     out  occupancy is DEPTH
//   overflow      out  sticky: a CPU byte was dropped on a full FIFO
//   clr_overflow  in   clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module rs232c_tx_sched
  import rs232c_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned ACK_WAIT = DEF_ACK_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_push,
  input  logic [BYTE_W-1:0] cpu_data,
  input  logic              dbg_valid,
  input  logic [BYTE_W-1:0] dbg_data,
  output logic              dbg_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic [AW:0]       fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int unsigned TW = cnt_width(ACK_WAIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_WAIT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tx_start_q, tx_start_d;
  byte_t         tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;

  logic  pop;
  logic  space;
  logic  cpu_drop;
  logic  fifo_push;
  byte_t fifo_wdata;
  byte_t fifo_rdata;

  // ---------------------------------------------------------------------------
  // Write arbitration: at most one FIFO write per cycle, CPU first.
  // A slot freed by this cycle's pop counts as space, so a full FIFO that is
  // being drained still accepts the byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    pop        = (state_q == ST_IDLE) && !fifo_empty && !tx_busy;
    space      = !fifo_full || pop;
    cpu_drop   = cpu_push && !space;
    dbg_ready  = dbg_valid && !cpu_push && space && !rst;
    fifo_push  = (cpu_push && space) || dbg_ready;
    fifo_wdata = cpu_push ? cpu_data : dbg_data;
  end

  rs232c_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // Transmit sequencer. The pop edge loads tx_data and raises tx_start for the
  // first ACK cycle; ACK therefore spans ACK_WAIT cycles including the start
  // pulse cycle before giving up on the transmitter acknowledging.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_data_d  = fifo_rdata;
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        if (tx_busy) begin
          state_d = ST_DRAIN;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A dropped push in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (cpu_drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rs232c_tx_sched.sv
module tb_rs232c_tx_sched;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int ACK_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_push;
  logic [7:0]    cpu_data;
  logic          dbg_valid;
  logic [7:0]    dbg_data;
  logic          dbg_ready;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [AW:0]   fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;
  logic          clr_overflow;

  rs232c_tx_sched #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ACK_WAIT (ACK_WAIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_push     (cpu_push),
    .cpu_data     (cpu_data),
    .dbg_valid    (dbg_valid),
    .dbg_data     (dbg_data),
    .dbg_ready    (dbg_ready),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .fifo_count   (fifo_count),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transmitter model: 0 = busy for 10 cycles starting the cycle after a
  // start pulse, 1 = busy held high, 2 = busy never rises.
  int busy_mode = 0;
  initial begin
    int cnt;
    bit pend;
    cnt = 0;
    pend = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend && busy_mode == 0) cnt = 10;
      pend = (tx_start === 1'b1);
      if (busy_mode == 1)      tx_busy = 1'b1;
      else if (busy_mode == 2) tx_busy = 1'b0;
      else                     tx_busy = (cnt > 0);
      if (cnt > 0) cnt--;
    end
  end

  // Log of what the DUT actually transmitted, with the cycle of each start.
  logic [7:0] dut_log[$];
  int         start_cyc[$];
  int         cyc = 0;

  // Reference model: a byte queue plus a transmitter reservation window.
  // After a start at cycle s the link is reserved until either busy has risen
  // and then been seen low (free the following cycle), or ACK_WAIT cycles from
  // s elapse without busy.
  initial begin
    logic [7:0] q[$];
    logic [7:0] m_data;
    bit m_valid, m_start, m_ovf, outst, acked, link_free, pop, space, exp_rdy, set_ovf;
    int s_cyc;
    m_valid = 0; m_start = 0; m_ovf = 0; m_data = '0; outst = 0; acked = 0; s_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start === 1'b1) begin
        dut_log.push_back(tx_data);
        start_cyc.push_back(cyc);
      end
      link_free = !outst;
      if (outst) begin
        if (acked) begin
          if (!tx_busy) outst = 0;
        end else if (tx_busy) begin
          acked = 1;
        end else if (cyc - s_cyc == ACK_WAIT - 1) begin
          outst = 0;
        end
      end
      pop     = link_free && (q.size() > 0) && !tx_busy;
      space   = (q.size() < DEPTH) || pop;
      exp_rdy = dbg_valid && !cpu_push && space && !rst;
      if (m_valid) begin
        check("tx_start",   tx_start,   m_start);
        check("tx_data",    tx_data,    m_data);
        check("fifo_count", fifo_count, q.size());
        check("fifo_empty", fifo_empty, q.size() == 0);
        check("fifo_full",  fifo_full,  q.size() == DEPTH);
        check("overflow",   overflow,   m_ovf);
        check("dbg_ready",  dbg_ready,  exp_rdy);
      end
      if (rst) begin
        q.delete();
        m_start = 0; m_data = '0; m_ovf = 0; outst = 0; acked = 0;
        m_valid = 1;
      end else if (m_valid) begin
        m_start = 0;
        if (pop) begin
          m_data  = q.pop_front();
          m_start = 1;
          outst   = 1;
          acked   = 0;
          s_cyc   = cyc + 1;
        end
        set_ovf = 0;
        if (cpu_push) begin
          if (space) q.push_back(cpu_data);
          else       set_ovf = 1;
        end else if (exp_rdy) begin
          q.push_back(dbg_data);
        end
        if (set_ovf)           m_ovf = 1;
        else if (clr_overflow) m_ovf = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int k;
    k = 0;
    while (fifo_empty !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check(name, fifo_empty, 1);
  endtask

  initial begin
    int base;
    rst = 1; cpu_push = 0; cpu_data = '0; dbg_valid = 0; dbg_data = '0; clr_overflow = 0;
    step(); step();
    rst = 0;
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_start", tx_start, 0);
    check("rst_data",  tx_data, 0);
    check("rst_ovf",   overflow, 0);

    // Single byte: start two cycles after the push, exactly one pulse.
    base = dut_log.size();
    step(); cpu_push = 1; cpu_data = 8'h41;
    step(); cpu_push = 0;
    check("t1_count1", fifo_count, 1);
    check("t1_nostart", tx_start, 0);
    step();
    check("t1_start", tx_start, 1);
    check("t1_data",  tx_data, 8'h41);
    repeat (20) step();
    check("t1_npulse", dut_log.size() - base, 1);
    check("t1_count0", fifo_count, 0);

    // Contention: CPU wins, debug byte follows.
    base = dut_log.size();
    step(); cpu_push = 1; cpu_data = 8'h01; dbg_valid = 1; dbg_data = 8'h02;
    #1 check("t2_rdy_blocked", dbg_ready, 0);
    step(); cpu_push = 0;
    #1 check("t2_rdy_next", dbg_ready, 1);
    step(); dbg_valid = 0;
    repeat (40) step();
    check("t2_n", dut_log.size() - base, 2);
    if (dut_log.size() - base == 2) begin
      check("t2_first",  dut_log[base],     8'h01);
      check("t2_second", dut_log[base + 1], 8'h02);
    end

    // Overflow: 17 pushes with the transmitter held busy.
    busy_mode = 1;
    step(); step();
    base = dut_log.size();
    for (int i = 0; i < 17; i++) begin
      step(); cpu_push = 1; cpu_data = 8'(i); dbg_valid = 1; dbg_data = 8'hEE;
      #1 check("t3_rdy", dbg_ready, 0);
      if (i == 15) check("t3_notfull15", fifo_full, 0);
      if (i == 16) check("t3_full16", fifo_full, 1);
    end
    step(); cpu_push = 0;
    #1 check("t3_rdy_full", dbg_ready, 0);
    check("t3_ovf", overflow, 1);
    check("t3_count", fifo_count, 16);
    step(); dbg_valid = 0;
    busy_mode = 0;
    wait_empty("t3_drained", 400);
    repeat (20) step();
    check("t3_n", dut_log.size() - base, 16);
    if (dut_log.size() - base == 16) begin
      for (int i = 0; i < 16; i++) check("t3_order", dut_log[base + i], i);
    end
    check("t3_ovf_sticky", overflow, 1);
    step(); clr_overflow = 1;
    step(); clr_overflow = 0;
    check("t3_ovf_clr", overflow, 0);

    // Full FIFO with a push in the same cycle as the pop.
    busy_mode = 1;
    step(); step();
    base = dut_log.size();
    for (int i = 0; i < 16; i++) begin
      step(); cpu_push = 1; cpu_data = 8'h60 + 8'(i);
    end
    step(); cpu_push = 0;
    check("t4_full", fifo_full, 1);
    busy_mode = 0;
    step(); cpu_push = 1; cpu_data = 8'h55;
    check("t4_busy_low", tx_busy, 0);
    step(); cpu_push = 0;
    check("t4_count16", fifo_count, 16);
    check("t4_no_ovf", overflow, 0);
    wait_empty("t4_drained", 400);
    repeat (20) step();
    check("t4_n", dut_log.size() - base, 17);
    if (dut_log.size() - base == 17) begin
      check("t4_first", dut_log[base], 8'h60);
      check("t4_last",  dut_log[base + 16], 8'h55);
    end

    // Lost ack: busy never rises, next start ACK_WAIT+1 cycles later.
    busy_mode = 2;
    step(); step();
    base = dut_log.size();
    step(); cpu_push = 1; cpu_data = 8'hA1;
    step(); cpu_data = 8'hA2;
    step(); cpu_push = 0;
    repeat (20) step();
    check("t5_n", dut_log.size() - base, 2);
    if (dut_log.size() - base == 2) begin
      check("t5_d0", dut_log[base], 8'hA1);
      check("t5_d1", dut_log[base + 1], 8'hA2);
      check("t5_gap", start_cyc[base + 1] - start_cyc[base], 5);
    end

    // Reset while draining with three bytes queued.
    busy_mode = 0;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      step(); cpu_push = 1; cpu_data = 8'hB0 + 8'(i);
    end
    step(); cpu_push = 0;
    step();
    check("t6_queued", fifo_count, 3);
    check("t6_busy", tx_busy, 1);
    rst = 1;
    step(); rst = 0;
    check("t6_count", fifo_count, 0);
    check("t6_empty", fifo_empty, 1);
    check("t6_ovf",   overflow, 0);
    check("t6_start", tx_start, 0);
    base = dut_log.size();
    repeat (25) step();
    check("t6_silent", dut_log.size() - base, 0);
    step(); cpu_push = 1; cpu_data = 8'hC3;
    step(); cpu_push = 0;
    step();
    check("t6_new_start", tx_start, 1);
    check("t6_new_data",  tx_data, 8'hC3);
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
